// File: rtl/rv32i_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_mem_pkg : shared types for the IF/MEM unified-port arbiter     |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Byte-enable width for the default 32-bit data path.
  localparam int DEF_DATA_W = 32;
  localparam int BE_W       = DEF_DATA_W / 8;

endpackage
`default_nettype wire

// File: rtl/rv32i_mem_arb_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_mem_arb_prio : MEM-first winner select with IF starvation cap  |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module rv32i_mem_arb_prio
  import rv32i_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  logic   arb_i,
  output owner_e win_o
);

  localparam int                 c_cnt_w = $clog2(STARVE_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(STARVE_MAX);

  logic [c_cnt_w-1:0] r_starve_cnt;
  logic               w_starved;

  assign w_starved = if_req_i & (r_starve_cnt == c_max);

  always_comb begin
    win_o = OWN_IF;
    if (d_req_i && !w_starved) begin
      win_o = OWN_D;
    end
  end

  // Counts data wins that bypassed a waiting fetch; any other grant resets it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve_cnt <= '0;
    end else if (arb_i && (if_req_i || d_req_i)) begin
      if (win_o == OWN_D && if_req_i) begin
        if (r_starve_cnt != c_max) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32i_mem_arbiter : IF/MEM sharing of one memory port, one txn open  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_W-1:0]     if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_W/8-1:0]   d_be_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  bus_err_o
);

  localparam int                c_wd_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0] c_timeout = c_wd_w'(TIMEOUT);

  state_e               r_state;
  owner_e               r_owner;
  logic                 r_mem_req;
  logic                 r_we;
  logic [DATA_W/8-1:0]  r_be;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [c_wd_w-1:0]    r_wd;

  owner_e w_win;
  logic   w_any;
  logic   w_arb;
  logic   w_hs;
  logic   w_rsp_ok;
  logic   w_err;
  logic   w_rsp;

  assign w_any    = if_req_i | d_req_i;
  assign w_arb    = (r_state == IDLE);
  assign w_hs     = (r_state == REQ) & mem_gnt_i;
  assign w_rsp_ok = (r_state == RSP) & mem_rvalid_i;
  // A response arriving on the timeout cycle takes precedence over the error.
  assign w_err    = (r_state == RSP) & ~mem_rvalid_i & (r_wd == c_timeout);
  assign w_rsp    = w_rsp_ok | w_err;

  rv32i_mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .if_req_i (if_req_i),
    .d_req_i  (d_req_i),
    .arb_i    (w_arb),
    .win_o    (w_win)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_owner   <= OWN_IF;
      r_mem_req <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wd      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner   <= w_win;
            r_mem_req <= 1'b1;
            r_state   <= REQ;
            if (w_win == OWN_D) begin
              r_we    <= d_we_i;
              r_be    <= d_be_i;
              r_addr  <= d_addr_i;
              r_wdata <= d_wdata_i;
            end else begin
              r_we    <= 1'b0;
              r_be    <= '1;
              r_addr  <= if_addr_i;
              r_wdata <= '0;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_wd      <= '0;
            r_state   <= RSP;
          end
        end
        RSP: begin
          if (w_rsp) begin
            r_state <= IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

  assign if_gnt_o    = w_hs & (r_owner == OWN_IF);
  assign d_gnt_o     = w_hs & (r_owner == OWN_D);
  assign if_rvalid_o = w_rsp & (r_owner == OWN_IF);
  assign d_rvalid_o  = w_rsp & (r_owner == OWN_D);
  assign if_rdata_o  = (w_rsp_ok && r_owner == OWN_IF) ? mem_rdata_i : '0;
  assign d_rdata_o   = (w_rsp_ok && r_owner == OWN_D)  ? mem_rdata_i : '0;
  assign bus_err_o   = w_err;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv32i_mem_arbiter : directed scoreboard bench for the arbiter     |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_rv32i_mem_arbiter;
  import rv32i_mem_pkg::*;

  // Memory responder returns address XOR this key as read data.
  localparam logic [31:0] c_key = 32'h0010_0083;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            if_req_i;
  logic [31:0]     if_addr_i;
  logic            if_gnt_o, if_rvalid_o;
  logic [31:0]     if_rdata_o;
  logic            d_req_i, d_we_i;
  logic [BE_W-1:0] d_be_i;
  logic [31:0]     d_addr_i, d_wdata_i;
  logic            d_gnt_o, d_rvalid_o;
  logic [31:0]     d_rdata_o;
  logic            mem_req_o, mem_we_o;
  logic [BE_W-1:0] mem_be_o;
  logic [31:0]     mem_addr_o, mem_wdata_o;
  logic            mem_gnt_i, mem_rvalid_i;
  logic [31:0]     mem_rdata_i;
  logic            bus_err_o;

  typedef struct {
    bit              own_d;
    logic [31:0]     addr;
    logic            we;
    logic [BE_W-1:0] be;
    logic [31:0]     wdata;
  } gnt_t;

  typedef struct {
    bit          own_d;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   checks    = 0;
  int   failures  = 0;
  int   gnt_delay = 0;
  bit   rsp_en    = 1'b1;
  int   inj_req   = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .bus_err_o(bus_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_tx(input bit own_d, input logic we, input logic [BE_W-1:0] be,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err, input bit has_rsp);
    gq.push_back('{own_d: own_d, addr: a, we: we, be: be, wdata: wd});
    if (has_rsp) rq.push_back('{own_d: own_d, data: rd, err: err});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit is_d);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = is_d ? d_gnt_o : if_gnt_o;
    end
    chk(is_d ? "d_gnt_wait" : "if_gnt_wait", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    if_addr_i = a;
    if_req_i  = 1'b1;
    wait_gnt(1'b0);
    if_req_i  = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [BE_W-1:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
    d_we_i    = we;
    d_be_i    = be;
    d_addr_i  = a;
    d_wdata_i = wd;
    d_req_i   = 1'b1;
    wait_gnt(1'b1);
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {21'd0, mem_req_o, mem_we_o, if_gnt_o, d_gnt_o,
                         if_rvalid_o, d_rvalid_o, bus_err_o, mem_be_o}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata_o, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata_o, 32'd0);
  endtask

  // Downstream memory: grant after gnt_delay REQ cycles, answer the cycle after.
  initial begin : responder
    int          req_cnt;
    int          inj_done;
    bit          had_gnt;
    logic [31:0] gaddr;
    req_cnt      = 0;
    inj_done     = 0;
    gaddr        = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      had_gnt      = mem_gnt_i && rst_n;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (had_gnt && rsp_en) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = gaddr ^ c_key;
      end else if (inj_done != inj_req) begin
        inj_done     = inj_req;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
      end
      if (mem_req_o && rst_n) begin
        if (req_cnt >= gnt_delay) begin
          mem_gnt_i = 1'b1;
          gaddr     = mem_addr_o;
          req_cnt   = 0;
        end else begin
          req_cnt++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  initial begin : monitor
    gnt_t g;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_req_o && mem_gnt_i) begin
          if (gq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_unexpected: addr 0x%08h granted, expected no grant", mem_addr_o);
          end else begin
            g = gq.pop_front();
            chk("gnt_if", {31'd0, if_gnt_o}, {31'd0, !g.own_d});
            chk("gnt_d", {31'd0, d_gnt_o}, {31'd0, g.own_d});
            chk("gnt_addr", mem_addr_o, g.addr);
            chk("gnt_we", {31'd0, mem_we_o}, {31'd0, g.we});
            chk("gnt_be", {28'd0, mem_be_o}, {28'd0, g.be});
            if (g.own_d) chk("gnt_wdata", mem_wdata_o, g.wdata);
          end
        end else begin
          chk("spurious_gnt", {30'd0, if_gnt_o, d_gnt_o}, 32'd0);
        end
        if (if_rvalid_o || d_rvalid_o) begin
          if (rq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: if_rvalid=%0b d_rvalid=%0b expected none",
                     if_rvalid_o, d_rvalid_o);
          end else begin
            r = rq.pop_front();
            chk("rsp_if_rvalid", {31'd0, if_rvalid_o}, {31'd0, !r.own_d});
            chk("rsp_d_rvalid", {31'd0, d_rvalid_o}, {31'd0, r.own_d});
            chk("rsp_rdata", r.own_d ? d_rdata_o : if_rdata_o, r.data);
            chk("rsp_other_rdata", r.own_d ? if_rdata_o : d_rdata_o, 32'd0);
            chk("rsp_bus_err", {31'd0, bus_err_o}, {31'd0, r.err});
          end
        end else begin
          chk("idle_bus_err", {31'd0, bus_err_o}, 32'd0);
        end
      end
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin : stimulus
    int req_cyc;
    int gcnt;
    int rvcnt;
    int errk;
    bit saw;
    rst_n     = 1'b0;
    if_req_i  = 1'b0;
    if_addr_i = '0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_be_i    = '0;
    d_addr_i  = '0;
    d_wdata_i = '0;

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single fetch with latency checks.
    exp_tx(1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'd0, 32'h0010_0093, 1'b0, 1'b1);
    if_addr_i = 32'h0000_0010;
    if_req_i  = 1'b1;
    @(negedge clk);
    chk("fetch_n_mem_req", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk);
    chk("fetch_n1_mem_req", {31'd0, mem_req_o}, 32'd1);
    chk("fetch_n1_we", {31'd0, mem_we_o}, 32'd0);
    chk("fetch_n1_be", {28'd0, mem_be_o}, 32'hF);
    chk("fetch_n1_if_gnt", {31'd0, if_gnt_o}, 32'd1);
    @(posedge clk);
    #1;
    if_req_i = 1'b0;
    @(negedge clk);
    chk("fetch_n2_rvalid", {31'd0, if_rvalid_o}, 32'd1);
    chk("fetch_n2_rdata", if_rdata_o, 32'h0010_0093);
    idle(3);

    // Starvation: four data grants, then IF, then the pending data request.
    exp_tx(1'b1, 1'b0, 4'hF, 32'h300, 32'd0, 32'h0010_0383, 1'b0, 1'b1);
    exp_tx(1'b1, 1'b0, 4'hF, 32'h304, 32'd0, 32'h0010_0387, 1'b0, 1'b1);
    exp_tx(1'b1, 1'b0, 4'hF, 32'h308, 32'd0, 32'h0010_038B, 1'b0, 1'b1);
    exp_tx(1'b1, 1'b0, 4'hF, 32'h30C, 32'd0, 32'h0010_038F, 1'b0, 1'b1);
    exp_tx(1'b0, 1'b0, 4'hF, 32'h040, 32'd0, 32'h0010_00C3, 1'b0, 1'b1);
    exp_tx(1'b1, 1'b0, 4'hF, 32'h310, 32'd0, 32'h0010_0393, 1'b0, 1'b1);
    fork
      do_fetch(32'h40);
      begin
        for (int i = 0; i < 5; i++) do_data(1'b0, 4'hF, 32'(32'h300 + 4 * i), 32'd0);
      end
    join
    idle(4);

    // Simultaneous load and fetch: data first (counter cleared above).
    exp_tx(1'b1, 1'b0, 4'hF, 32'h100, 32'd0, 32'h0010_0183, 1'b0, 1'b1);
    exp_tx(1'b0, 1'b0, 4'hF, 32'h020, 32'd0, 32'h0010_00A3, 1'b0, 1'b1);
    fork
      do_fetch(32'h20);
      do_data(1'b0, 4'hF, 32'h100, 32'd0);
    join
    idle(4);

    // Store with a 3-cycle grant delay.
    gnt_delay = 3;
    exp_tx(1'b1, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF, 32'h0010_0283, 1'b0, 1'b1);
    d_we_i    = 1'b1;
    d_be_i    = 4'b0011;
    d_addr_i  = 32'h200;
    d_wdata_i = 32'hDEAD_BEEF;
    d_req_i   = 1'b1;
    req_cyc   = 0;
    gcnt      = 0;
    rvcnt     = 0;
    saw       = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (mem_req_o) begin
        req_cyc++;
        chk("store_addr", mem_addr_o, 32'h200);
        chk("store_we", {31'd0, mem_we_o}, 32'd1);
        chk("store_be", {28'd0, mem_be_o}, 32'h3);
        chk("store_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      end
      if (d_gnt_o) begin
        gcnt++;
        saw = 1'b1;
      end
      if (d_rvalid_o) rvcnt++;
      @(posedge clk);
      #1;
      if (saw) begin
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
      end
    end
    chk("store_req_cycles", req_cyc, 32'd4);
    chk("store_gnt_pulses", gcnt, 32'd1);
    chk("store_rvalid_pulses", rvcnt, 32'd1);
    gnt_delay = 0;
    idle(2);

    // Watchdog timeout: no response ever arrives.
    rsp_en = 1'b0;
    exp_tx(1'b1, 1'b0, 4'hF, 32'h400, 32'd0, 32'd0, 1'b1, 1'b1);
    do_data(1'b0, 4'hF, 32'h400, 32'd0);
    errk = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus_err_o && errk == 0) begin
        errk = k;
        chk("timeout_d_rvalid", {31'd0, d_rvalid_o}, 32'd1);
        chk("timeout_d_rdata", d_rdata_o, 32'd0);
      end
    end
    chk("timeout_cycle", errk, 32'd9);
    idle(1);

    // Asynchronous reset while waiting in RSP.
    exp_tx(1'b0, 1'b0, 4'hF, 32'h080, 32'd0, 32'd0, 1'b0, 1'b0);
    do_fetch(32'h80);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    rsp_en = 1'b1;
    inj_req++;
    @(negedge clk);
    chk("late_rvalid_ignored", {29'd0, if_rvalid_o, d_rvalid_o, mem_req_o}, 32'd0);
    idle(2);
    exp_tx(1'b0, 1'b0, 4'hF, 32'h084, 32'd0, 32'h0010_0007, 1'b0, 1'b1);
    do_fetch(32'h84);
    idle(4);

    chk("grant_queue_drained", gq.size(), 32'd0);
    chk("rsp_queue_drained", rq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
